// File: rtl/approx_mult_pkg.sv
// Shared encodings for the nibble-serial approximate multiplier.
// Holds the mode values, the FSM state type and the approximate low-bit pattern.
package approx_mult_pkg;

    localparam logic [1:0] MODE_EXACT   = 2'b00;
    localparam logic [1:0] MODE_APX_ADD = 2'b01;
    localparam logic [1:0] MODE_APX_OR  = 2'b10;

    // Low two bits forced onto an approximated 4x4 product.
    localparam logic [1:0] APX_LOW = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/approx_mul4x4.sv
// Combinational 4x4 multiplier with optional low-bit approximation.
// Products below 4 are always exact; larger ones get their two LSBs replaced.
module approx_mul4x4
    import approx_mult_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       apx,
    output logic [7:0] p
);

    logic [7:0] p_exact;

    always_comb begin
        p_exact = {4'b0, x} * {4'b0, y};
        if (apx && (p_exact >= 8'd4)) begin
            p = {p_exact[7:2], APX_LOW};
        end else begin
            p = p_exact;
        end
    end

endmodule

// File: rtl/approx_mult_seq.sv
// Sequential nibble-by-nibble multiplier: one 4x4 block per cycle, exact or approximate,
// combined by add or OR into a 2*WIDTH accumulator, with a valid/ready handshake each side.
module approx_mult_seq
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_DIAG = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] r
);

    localparam int K  = WIDTH / 4;
    localparam int CW = $clog2(K);
    localparam int SW = CW + 1;
    localparam int RW = 2 * WIDTH;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       mode_q;
    logic [RW-1:0]    acc, acc_nx, blk_shifted;
    logic [CW-1:0]    ci, cj;
    logic             issued_all;
    logic             pv;
    logic [7:0]       prod_q;
    logic [SW-1:0]    sh_q;

    logic [3:0]       x, y;
    logic             apx, apx_mode, or_mode;
    logic [7:0]       p;
    logic             accept;
    logic             row_last, col_last;

    assign accept   = (state == ST_IDLE) && in_valid;
    assign row_last = (ci == CW'(K - 1));
    assign col_last = (cj == CW'(K - 1));

    // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        apx_mode = 1'b0;
        or_mode  = 1'b0;
        case (mode_q)
            MODE_EXACT:   ;
            MODE_APX_ADD: apx_mode = 1'b1;
            MODE_APX_OR: begin
                apx_mode = 1'b1;
                or_mode  = 1'b1;
            end
            default:      ;
        endcase
    end

    // Block operand select from the registered operands; (ci, cj) walks i outer, j inner.
    always_comb begin
        x   = 4'(a_q >> {ci, 2'b00});
        y   = 4'(b_q >> {cj, 2'b00});
        apx = apx_mode && ((int'(ci) + int'(cj)) < APPROX_DIAG);
    end

    approx_mul4x4 u_mul (
        .x   (x),
        .y   (y),
        .apx (apx),
        .p   (p)
    );

    always_comb begin
        blk_shifted = RW'(prod_q) << {sh_q, 2'b00};
        acc_nx      = or_mode ? (acc | blk_shifted) : (acc + blk_shifted);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (in_valid)            state_nx = ST_CALC;
            ST_CALC: if (issued_all && pv)    state_nx = ST_DONE;
            ST_DONE: if (out_ready)           state_nx = ST_IDLE;
            default:                          state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        r         = '0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                r         = acc;
            end
            default: ;
        endcase
    end

    // The product is registered before accumulation, so the last block lands one cycle
    // after it is issued and the multiply and accumulate never share a cycle.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            acc        <= '0;
            ci         <= '0;
            cj         <= '0;
            issued_all <= 1'b0;
            pv         <= 1'b0;
        end else if (state == ST_CALC) begin
            if (pv) begin
                acc <= acc_nx;
            end
            pv <= !issued_all;
            if (!issued_all) begin
                if (col_last) begin
                    cj <= '0;
                    if (row_last) begin
                        issued_all <= 1'b1;
                    end else begin
                        ci <= ci + CW'(1);
                    end
                end else begin
                    cj <= cj + CW'(1);
                end
            end
        end
    end

    // NOTE: pure datapath registers carry no reset; each is written before any control path reads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
        end
        if ((state == ST_CALC) && !issued_all) begin
            prod_q <= p;
            sh_q   <= SW'(ci) + SW'(cj);
        end
    end

endmodule
